// File: rtl/ram_arbiter.sv
// Single-port program RAM arbiter between CPU instruction fetch and the loader/debug port.
// Tie-break policy: define ARB_ROUND_ROBIN_EN for round-robin, otherwise CPU has fixed priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_ins,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  input  logic              ld_hold,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_ld
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_cpu_ins;
  logic [DATA_W-1:0]  r_ld_rdata;
  logic               r_cpu_ack;
  logic               r_ld_ack;
  logic               r_ram_en;
  logic               r_ram_we;
  logic               r_busy;
  logic               r_grant_ld;

  logic               w_cpu_elig;
  logic               w_ld_elig;
  logic               w_pick_ld;

  assign w_cpu_elig = cpu_req & ~ld_hold;
  assign w_ld_elig  = ld_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer remembers who was granted last; reset value lets the CPU win the first tie.
  logic r_last_ld;
  assign w_pick_ld = w_ld_elig & (~w_cpu_elig | ~r_last_ld);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_ld <= 1'b1;
    end else if (r_state == S_IDLE && (w_cpu_elig || w_ld_elig)) begin
      r_last_ld <= w_pick_ld;
    end
  end
`else
  assign w_pick_ld = w_ld_elig & ~w_cpu_elig;
`endif

  // Transaction sequencer: grant, one-cycle issue, latency countdown, ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_ins  <= '0;
      r_ld_rdata <= '0;
      r_cpu_ack  <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_grant_ld <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_ld_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cpu_elig || w_ld_elig) begin
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
            r_ram_en   <= 1'b1;
            r_grant_ld <= w_pick_ld;
            if (w_pick_ld) begin
              r_addr   <= ld_addr;
              r_wdata  <= ld_wdata;
              r_we     <= ld_we;
              r_ram_we <= ld_we;
            end else begin
              r_addr   <= cpu_addr;
              r_wdata  <= '0;
              r_we     <= 1'b0;
              r_ram_we <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_we) begin
            r_state   <= S_DONE;
            r_cpu_ack <= ~r_grant_ld;
            r_ld_ack  <= r_grant_ld;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(RAM_LAT - 1);
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= S_DONE;
            r_cpu_ack <= ~r_grant_ld;
            r_ld_ack  <= r_grant_ld;
            if (r_grant_ld) begin
              r_ld_rdata <= ram_rdata;
            end else begin
              r_cpu_ins <= ram_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ins   = r_cpu_ins;
  assign cpu_ack   = r_cpu_ack;
  assign ld_rdata  = r_ld_rdata;
  assign ld_ack    = r_ld_ack;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = r_busy;
  assign grant_ld  = r_grant_ld;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port program RAM between the CPU instruction-fetch port and the program loader/debug port. Each requester gets a req/ack handshake, and all RAM traffic is sequenced through one FSM with a fixed, parameterised read latency. The block sits between the CPU top level and the RAM:
- the CPU's `en_ram_in`/`addr` drive `cpu_req`/`cpu_addr`;
- `cpu_ack`/`cpu_ins` feed the CPU's `en_ram_out`/`ins`.

## Interface
Parameters:
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data/instruction width.
- `RAM_LAT`, 2, cycles from the `ram_en` cycle to valid `ram_rdata`; legal range is 1..7.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU fetch request; held high until `cpu_ack`.
- `cpu_addr`  in  ADDR_W  fetch address; stable while `cpu_req` is high.
- `cpu_ins`  out  DATA_W  fetched word; registered, valid with `cpu_ack`, holds until the next CPU read.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `ld_req`  in  1  loader request; held high until `ld_ack`.
- `ld_we`  in  1  1 = write, 0 = read.
- `ld_addr`  in  ADDR_W  loader address.
- `ld_wdata`  in  DATA_W  loader write data.
- `ld_rdata`  out  DATA_W  loader read data; registered, valid with `ld_ack`.
- `ld_ack`  out  1  one-cycle completion pulse.
- `ld_hold`  in  1  level; while high, CPU requests are not granted.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data.
- `busy`  out  1  high in any state other than IDLE.
- `grant_ld`  out  1  owner of the current or last transaction (1 = loader).

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.

IDLE:
- A CPU request is eligible when `cpu_req & ~ld_hold`. A loader request is eligible when `ld_req`.
- If either is eligible, choose the winner (see Configuration), go to ISSUE, and latch the winner's address, write-enable (0 for CPU) and write data. Set `grant_ld`.

ISSUE (exactly one cycle):
- `ram_en` = 1; `ram_we` = latched write-enable.
- A write goes to DONE. A read goes to WAIT, with the counter loaded to RAM_LAT−1.

WAIT:
- Decrement the counter each cycle.
- When the counter is 0, capture `ram_rdata` into `cpu_ins` or `ld_rdata` (per owner) and go to DONE.
- With RAM_LAT=1, WAIT lasts a single cycle.

DONE (one cycle):
- Assert the owner's ack. Next state is IDLE.
- The requester drops `req`, or re-presents a new request, at the edge where it samples ack.

Datapath rules:
- `ram_addr`/`ram_wdata` always show the latched values; `ram_we` = latched write-enable AND ISSUE.
- Request inputs that change after the grant are ignored until the next IDLE.
- Writes never update `cpu_ins`/`ld_rdata`.
- The CPU never writes.
- `ld_hold` asserted mid-transaction does not abort a CPU access already granted.

Reset (`rst` = 0 at an edge):
- State goes to IDLE.
- `ram_en`, `ram_we`, `cpu_ack`, `ld_ack`, `busy`, `grant_ld` go to 0.
- `cpu_ins`, `ld_rdata`, `ram_addr`, `ram_wdata` go to 0. Counter goes to 0.
- Round-robin pointer goes to "loader served last".
- An in-flight transaction is dropped and never acked.

## Timing
- Read: request high in IDLE cycle 0 → `ram_en` in cycle 1 → data captured at the end of cycle 1+RAM_LAT → ack in cycle 2+RAM_LAT.
- Write: `ram_en`+`ram_we` in cycle 1, ack in cycle 2.
- One transaction at a time. Minimum spacing between grants is one IDLE cycle, so back-to-back reads sustain one access every RAM_LAT+3 cycles.
- Ack and read data are registered outputs; there is no combinational path from req to ack.

## Configuration
Macro `ARB_ROUND_ROBIN_EN` selects the tie-break policy when both requests are eligible in IDLE.

- **Defined:** the winner is the requester not served last; the pointer updates on every grant. After reset the CPU wins the first tie.
- **Undefined:** fixed priority, CPU always wins ties. The loader is served only when the CPU is idle or `ld_hold` = 1.

## Test plan
1. **CPU read alone** (RAM_LAT=2, `cpu_addr`=0x0010, RAM returns 0xA5C3) → `ram_en` in cycle 1 with `ram_addr`=0x0010, `cpu_ack` in cycle 4 with `cpu_ins`=0xA5C3, `ld_ack` stays 0.
2. **Loader write** (`ld_addr`=0x0020, `ld_wdata`=0x1234) → `ram_en`=`ram_we`=1 in cycle 1, `ld_ack` in cycle 2, `cpu_ins`/`ld_rdata` unchanged.
3. **Both requesting continuously for 4 grants:**
   - with the macro: grant order CPU, LD, CPU, LD;
   - without the macro: CPU ×4, `ld_ack` never asserts.
4. **`ld_hold`=1 with `cpu_req` and `ld_req` high** (loader reads 0x0005 → 0xBEEF) → only the loader is served, `ld_rdata`=0xBEEF. Deassert `ld_hold` → CPU granted at the next IDLE.
5. **`rst`=0 during a CPU read's WAIT cycle** → no `cpu_ack`, all outputs 0 next cycle. A new CPU read issued after reset completes normally with ack at cycle 2+RAM_LAT.
6. **RAM_LAT=1 and RAM_LAT=7 sweeps** → CPU read ack at cycle 3 and cycle 9 respectively, with correct data.
